// File: rtl/sm_ptp_pkg.sv
// Shared PTP egress-timestamp definitions: default widths and the result status encoding.
package sm_ptp_pkg;

  localparam int FP_W_DEF = 20;
  localparam int TS_W_DEF = 96;

  typedef enum logic [1:0] {
    ST_MATCH   = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_FLUSH   = 2'b10
  } ptp_status_e;

  // Result priority: a present timestamp always decides, timeout only when none arrived.
  function automatic ptp_status_e status_enc(input logic match, input logic flush);
    if (match)      return ST_MATCH;
    else if (flush) return ST_FLUSH;
    else            return ST_TIMEOUT;
  endfunction

endpackage

// File: rtl/sm_ptp_fp_fifo.sv
// In-order fingerprint queue with first-word-fall-through head and registered count.
module sm_ptp_fp_fifo #(
  parameter  int W     = 20,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic                    push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sm_ptp_txts_matcher.sv
// Matches egress timestamps to queued timestamp requests in order; optional debug
// counters are built only when SM_PTP_TXTS_DBG_CNTR_EN is defined.
module sm_ptp_txts_matcher
  import sm_ptp_pkg::*;
#(
  parameter int FP_W  = FP_W_DEF,
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = 16,
  parameter int TMO_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TMO_W-1:0]         tmo_cycles,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [FP_W-1:0]          req_fp,
  input  logic                     ts_valid,
  input  logic [FP_W-1:0]          ts_fp,
  input  logic [TS_W-1:0]          ts_data,
  output logic                     out_valid,
  output logic [FP_W-1:0]          out_fp,
  output logic [TS_W-1:0]          out_ts,
  output logic [1:0]               out_status,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              cnt_match,
  output logic [31:0]              cnt_flush,
  output logic [31:0]              cnt_tmo,
  output logic [31:0]              cnt_orphan
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic            run_q;
  logic            push, pop;
  logic            full, empty;
  logic [FP_W-1:0] head_fp;
  logic [CW-1:0]   count;
  logic [TMO_W-1:0] age;
  logic            match_ev, flush_ev, tmo_ev;

  // run_q holds req_ready low through reset and releases it one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= 1'b1;
  end

  assign req_ready = run_q & ~full;
  assign push      = req_valid & req_ready;
  assign occupancy = count;

  assign match_ev = ts_valid & ~empty & (ts_fp == head_fp);
  assign flush_ev = ts_valid & ~empty & (ts_fp != head_fp);
  assign tmo_ev   = ~ts_valid & ~empty & (tmo_cycles != '0) &
                    (age == tmo_cycles - TMO_W'(1));
  assign pop      = match_ev | flush_ev | tmo_ev;

  sm_ptp_fp_fifo #(
    .W     (FP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (req_fp),
    .pop   (pop),
    .head  (head_fp),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Age restarts whenever a new entry becomes head (pop, or push into an empty queue).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                age <= '0;
    else if (pop || empty)  age <= '0;
    else if (age != '1)     age <= age + TMO_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_fp     <= '0;
      out_ts     <= '0;
      out_status <= ST_MATCH;
    end else begin
      out_valid <= pop;
      if (pop) begin
        out_fp     <= head_fp;
        out_ts     <= match_ev ? ts_data : '0;
        out_status <= status_enc(match_ev, flush_ev);
      end
    end
  end

`ifdef SM_PTP_TXTS_DBG_CNTR_EN
  logic orphan_ev;
  // A flushed timestamp is also an orphan: it found no request to land on.
  assign orphan_ev = ts_valid & ~match_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_match  <= '0;
      cnt_flush  <= '0;
      cnt_tmo    <= '0;
      cnt_orphan <= '0;
    end else begin
      cnt_match  <= cnt_match  + {31'd0, match_ev};
      cnt_flush  <= cnt_flush  + {31'd0, flush_ev};
      cnt_tmo    <= cnt_tmo    + {31'd0, tmo_ev};
      cnt_orphan <= cnt_orphan + {31'd0, orphan_ev};
    end
  end
`else
  assign cnt_match  = '0;
  assign cnt_flush  = '0;
  assign cnt_tmo    = '0;
  assign cnt_orphan = '0;
`endif

endmodule

// File: doc/sm_ptp_txts_matcher.md
SM_PTP_TXTS_MATCHER -- requirements
Module: sm_ptp_txts_matcher

Interface
REQ-001 SHALL have parameter FP_W, default 20, meaning the timestamp-request fingerprint width.
REQ-002 SHALL have parameter TS_W, default 96, meaning the egress timestamp width.
REQ-003 SHALL have parameter DEPTH, default 16, meaning the number of outstanding requests; a power of 2, at least 2.
REQ-004 SHALL have parameter TMO_W, default 16, meaning the timeout counter width.
REQ-005 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, asynchronous, active-high reset).
REQ-006 SHALL have port tmo_cycles (in, TMO_W): head-of-queue timeout in cycles; 0 disables the timeout.
REQ-007 SHALL have ports req_valid (in, 1), req_ready (out, 1) and req_fp (in, FP_W): the request push handshake.
REQ-008 SHALL have ports ts_valid (in, 1), ts_fp (in, FP_W) and ts_data (in, TS_W): the egress timestamp; always accepted, no backpressure.
REQ-009 SHALL have ports out_valid (out, 1), out_fp (out, FP_W), out_ts (out, TS_W) and out_status (out, 2): the result pulse, with no backpressure.
REQ-010 SHALL have port occupancy (out, $clog2(DEPTH)+1): the outstanding request count.
REQ-011 SHALL have ports cnt_match, cnt_flush, cnt_tmo and cnt_orphan (out, 32 each): the debug counters.

Function
REQ-012 SHALL push req_fp into an in-order queue when req_valid and req_ready are both high; req_ready = !full.
REQ-013 SHALL use the registered occupancy for req_ready; when full, a push is refused even if a pop occurs in the same cycle.
REQ-014 SHALL support a simultaneous push and pop when not full; occupancy is then unchanged.
REQ-015 SHALL, on ts_valid with a non-empty queue and ts_fp == head fp, pop the head and emit out_status=00 (MATCH) with out_ts=ts_data.
REQ-016 SHALL, on ts_valid with a non-empty queue and ts_fp != head fp, pop the head, emit out_status=10 (FLUSH) with out_ts=0, and discard the timestamp as orphan.
REQ-017 SHALL, on ts_valid with an empty queue, emit no output and count an orphan.
REQ-018 SHALL keep a head age counter: cleared when the head changes or the queue is empty, otherwise incremented each cycle and saturating at all-ones.
REQ-019 SHALL, when tmo_cycles != 0, no ts_valid is present and age == tmo_cycles-1, pop the head and emit out_status=01 (TIMEOUT) with out_ts=0.
REQ-020 SHALL give ts_valid priority over a timeout in the same cycle.
REQ-021 SHALL pop at most one entry per cycle.
REQ-022 SHALL register all outputs: out_valid is a 1-cycle pulse, 1 cycle after the triggering event; out_fp is the popped fingerprint.
REQ-023 SHALL wrap the read/write pointers modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-024 SHALL never encode out_status=11.

Reset
REQ-025 SHALL, on rst (asynchronous), empty the queue and zero the pointers, age, occupancy, out_valid, out_fp, out_ts, out_status and all counters; req_ready=0 during reset and 1 from the first cycle after release.
REQ-026 SHALL, on reset mid-operation, drop all outstanding requests silently with no output pulse.

Configuration
REQ-027 SHALL, with macro SM_PTP_TXTS_DBG_CNTR_EN defined, implement the four 32-bit counters: increment by 1 per match/flush/timeout/orphan event, wrap at 2^32, cleared only by rst.
REQ-028 SHALL, without SM_PTP_TXTS_DBG_CNTR_EN, tie all four counters to constant 0 with no counter flops.

Structure
REQ-029 SHALL take the default values for FP_W and TS_W from the shared package sm_ptp_pkg.
REQ-030 SHALL place the status enum type (MATCH=2'b00, TIMEOUT=2'b01, FLUSH=2'b10) in sm_ptp_pkg.
REQ-031 SHALL implement the queue as sub-module sm_ptp_fp_fifo (parametrised width/depth, first-word-fall-through head, full/empty/count outputs).

Verification
REQ-032 SHALL cover: push fp 0x00011, then ts fp 0x00011 with ts 0xABC -> next cycle out_valid=1, status 00, out_ts 0xABC, occupancy 0.
REQ-033 SHALL cover: push 0x1 and 0x2, then ts fp 0x2 -> status 10 with out_fp 0x1; 0x2 remains with occupancy 1; cnt_orphan=1 and cnt_flush=1 (macro on).
REQ-034 SHALL cover: tmo_cycles=5, push 0x7 and no ts -> status 01 with out_fp 0x7 exactly 5 cycles after the head became valid, plus 1 output register cycle; tmo_cycles=0 -> never times out.
REQ-035 SHALL cover: fill DEPTH=16 entries -> req_ready=0 and occupancy 16; a push with a simultaneous matching ts is refused; the next cycle req_ready=1.
REQ-036 SHALL cover: ts_valid on the same cycle the timeout expires, with a matching fp -> status 00 only, single pulse.
REQ-037 SHALL cover: rst asserted with 3 outstanding entries -> outputs immediately 0 and no pulse; after release occupancy 0; builds run with and without SM_PTP_TXTS_DBG_CNTR_EN (counters constant 0 when the macro is off).
